// File: rtl/riscv_pkg.sv
// Shared RISC-V core encodings: writeback result-source selects and load funct3 codes.
package riscv_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Aligns a byte/half/word out of the raw memory word and sign- or zero-extends it to XLEN.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Half select uses only off[1]; a misaligned halfword has already trapped upstream.
  assign byte_v = data[{off, 3'b000} +: 8];
  assign half_v = data[{off[1], 4'b0000} +: 16];
  assign word_v = data[31:0];

  // NOTE: every path assigns ext (default first), so no latch is inferred.
  always_comb begin
    ext = data;
    unique case (funct3)
      F3_LB:   ext = XLEN'($signed(byte_v));
      F3_LBU:  ext = XLEN'(byte_v);
      F3_LH:   ext = XLEN'($signed(half_v));
      F3_LHU:  ext = XLEN'(half_v);
      F3_LW:   ext = XLEN'($signed(word_v));
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/writeback_stage_p.sv
// MEM/WB pipeline register with stall/flush, four-way result mux, x0-suppressed
// register-file write enable and a retired-instruction counter.
module writeback_stage_p
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int RET_CNT_W  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stallW,
  input  logic                  flushW,
  input  logic                  validM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [2:0]            LoadTypeM,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]       ALU_ResultM,
  input  logic [XLEN-1:0]       ReadDataM,
  input  logic [XLEN-1:0]       PCPlus4M,
  input  logic [XLEN-1:0]       ImmExtM,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] RdW,
  output logic [XLEN-1:0]       ResultW,
  output logic                  validW,
  output logic [RET_CNT_W-1:0]  instret
);

  logic                  valid_q;
  logic                  regwrite_q;
  logic [1:0]            src_q;
  logic [2:0]            ltype_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       alu_q;
  logic [XLEN-1:0]       rdata_q;
  logic [XLEN-1:0]       pc4_q;
  logic [XLEN-1:0]       imm_q;
  logic [RET_CNT_W-1:0]  instret_q;
  logic [XLEN-1:0]       load_val;

  // NOTE: state uses non-blocking assignments; every field, datapath included, is
  // reset so a bubble's ResultW is deterministic rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      ltype_q    <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (flushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= '0;
      ltype_q    <= '0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
    end else if (!stallW) begin
      valid_q    <= validM;
      regwrite_q <= RegWriteM;
      src_q      <= ResultSrcM;
      ltype_q    <= LoadTypeM;
      rd_q       <= RdM;
      alu_q      <= ALU_ResultM;
      rdata_q    <= ReadDataM;
      pc4_q      <= PCPlus4M;
      imm_q      <= ImmExtM;
    end
  end

  // The W instruction retires on the edge where it is not stalled, whether or not
  // a flush lands behind it; the counter wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (valid_q && !stallW) begin
      instret_q <= instret_q + RET_CNT_W'(1);
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data   (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (ltype_q),
    .ext    (load_val)
  );

  always_comb begin
    ResultW = alu_q;
    unique case (src_q)
      RES_ALU: ResultW = alu_q;
      RES_MEM: ResultW = load_val;
      RES_PC4: ResultW = pc4_q;
      RES_IMM: ResultW = imm_q;
      default: ResultW = alu_q;
    endcase
  end

  // A stalled instruction writes only on its release cycle, and never to x0.
  assign RegWriteW = regwrite_q & valid_q & ~stallW & (rd_q != '0);
  assign RdW       = rd_q;
  assign validW    = valid_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Scoreboard bench for writeback_stage_p: a driver models each instruction's expected
// register write, a negedge monitor pops and compares; a 4-bit-counter twin checks wrap.
module tb_writeback_stage_p;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  lt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] imm;
  } winstr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] result;
    logic [63:0] cnt;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallW = 1'b0, flushW = 1'b0;
  logic        validM = 1'b0, RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [2:0]  LoadTypeM = '0;
  logic [4:0]  RdM = '0;
  logic [31:0] ALU_ResultM = '0, ReadDataM = '0, PCPlus4M = '0, ImmExtM = '0;

  logic        RegWriteW, validW, RegWriteW4, validW4;
  logic [4:0]  RdW, RdW4;
  logic [31:0] ResultW, ResultW4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  int tests = 0;
  int fails = 0;
  bit in_reset = 1'b1;
  winstr_t mw = '0;
  logic [63:0] cnt = '0;
  wr_t sb[$];

  always #5 clk = ~clk;

  writeback_stage_p dut (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .validW(validW), .instret(instret)
  );

  writeback_stage_p #(.RET_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW), .validM(validM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM), .RdM(RdM),
    .ALU_ResultM(ALU_ResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M),
    .ImmExtM(ImmExtM), .RegWriteW(RegWriteW4), .RdW(RdW4), .ResultW(ResultW4),
    .validW(validW4), .instret(instret4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what the writeback value of an instruction should be, from the ISA rules.
  function automatic logic [31:0] exp_result(input winstr_t w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w.rdata >> (8 * w.alu[1:0]));
    h = 16'(w.rdata >> (w.alu[1] ? 16 : 0));
    case (w.src)
      2'd0: return w.alu;
      2'd2: return w.pc4;
      2'd3: return w.imm;
      default: begin
        case (w.lt)
          3'b000:  return {{24{b[7]}}, b};
          3'b100:  return {24'd0, b};
          3'b001:  return {{16{h[15]}}, h};
          3'b101:  return {16'd0, h};
          default: return w.rdata;
        endcase
      end
    endcase
  endfunction

  function automatic winstr_t mk(input logic [1:0] src, input logic [2:0] lt,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] rdata, input logic [31:0] pc4,
                                 input logic [31:0] imm);
    winstr_t m;
    m = '{valid: 1'b1, rw: 1'b1, src: src, lt: lt, rd: rd,
          alu: alu, rdata: rdata, pc4: pc4, imm: imm};
    return m;
  endfunction

  // Called at posedge+1; drives M inputs for the coming edge and advances the model.
  task automatic step(input winstr_t m, input logic stall, input logic flush);
    winstr_t nxt;
    bit      retire;
    validM = m.valid; RegWriteM = m.rw; ResultSrcM = m.src; LoadTypeM = m.lt;
    RdM = m.rd; ALU_ResultM = m.alu; ReadDataM = m.rdata; PCPlus4M = m.pc4;
    ImmExtM = m.imm; stallW = stall; flushW = flush;
    retire = mw.valid && !stall;
    if (retire && mw.rw && mw.rd != 0)
      sb.push_back('{rd: mw.rd, result: exp_result(mw), cnt: cnt});
    nxt = flush ? winstr_t'('0) : (stall ? mw : m);
    @(posedge clk);
    #1;
    mw = nxt;
    if (retire) cnt = cnt + 1;
  endtask

  task automatic expect_res(input string name, input logic [31:0] r);
    #1;
    check(name, {32'd0, ResultW}, {32'd0, r});
  endtask

  task automatic reset_mid();
    step(mk(2'd0, 3'd0, 5'd3, 32'h55, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    check("pre_reset_validW", {63'd0, validW}, 64'd1);
    #2;
    rst = 1'b1;
    in_reset = 1'b1;
    #1;
    check("rst_validW", {63'd0, validW}, 64'd0);
    check("rst_regwrite", {63'd0, RegWriteW}, 64'd0);
    check("rst_rd", {59'd0, RdW}, 64'd0);
    check("rst_result", {32'd0, ResultW}, 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_instret4", {60'd0, instret4}, 64'd0);
    mw = '0;
    cnt = '0;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      check("validW", {63'd0, validW}, {63'd0, mw.valid});
      check("instret", instret, cnt);
      check("instret4", {60'd0, instret4}, {60'd0, cnt[3:0]});
      if (RegWriteW) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {63'd0, RegWriteW}, 64'd0);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_rd", {59'd0, RdW}, {59'd0, e.rd});
          check("wr_result", {32'd0, ResultW}, {32'd0, e.result});
          check("wr_instret", instret, e.cnt);
        end
      end else if (sb.size() != 0) begin
        check("missing_write", {63'd0, RegWriteW}, 64'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    winstr_t bub;
    winstr_t m;
    bub = '0;
    #2;
    check("init_validW", {63'd0, validW}, 64'd0);
    check("init_instret", instret, 64'd0);
    check("init_result", {32'd0, ResultW}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_reset = 1'b0;

    // ALU path
    step(mk(2'd0, 3'd0, 5'd5, 32'h0000000A, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("alu_result", 32'h0000000A);
    check("alu_rd", {59'd0, RdW}, 64'd5);
    step(bub, 1'b0, 1'b0);
    check("alu_instret", instret, 64'd1);

    // Loads from 0x8081F0F7 at byte offset 2
    step(mk(2'd1, 3'b000, 5'd6, 32'h00000002, 32'h8081F0F7, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("lb", 32'hFFFFFF81);
    step(mk(2'd1, 3'b100, 5'd6, 32'h00000002, 32'h8081F0F7, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("lbu", 32'h00000081);
    step(mk(2'd1, 3'b001, 5'd6, 32'h00000002, 32'h8081F0F7, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("lh", 32'hFFFF8081);
    step(mk(2'd1, 3'b101, 5'd6, 32'h00000002, 32'h8081F0F7, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("lhu", 32'h00008081);
    step(mk(2'd1, 3'b010, 5'd6, 32'h00000002, 32'h8081F0F7, 32'h0, 32'h0), 1'b0, 1'b0);
    expect_res("lw", 32'h8081F0F7);

    // Other sources and the x0 destination
    step(mk(2'd2, 3'd0, 5'd1, 32'h0, 32'h0, 32'h00000104, 32'h0), 1'b0, 1'b0);
    expect_res("pc4", 32'h00000104);
    step(mk(2'd3, 3'd0, 5'd2, 32'h0, 32'h0, 32'h0, 32'h12345000), 1'b0, 1'b0);
    expect_res("imm", 32'h12345000);
    step(mk(2'd0, 3'd0, 5'd0, 32'hDEAD, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    step(bub, 1'b0, 1'b0);
    check("x0_counted", instret, 64'd9);

    // Three-cycle stall, then release
    step(mk(2'd0, 3'd0, 5'd7, 32'h77, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(mk(2'd0, 3'd0, 5'd8, 32'h88, 32'h0, 32'h0, 32'h0), 1'b1, 1'b0);
      check("stall_hold_rd", {59'd0, RdW}, 64'd7);
    end
    check("stall_instret", instret, 64'd9);
    step(bub, 1'b0, 1'b0);
    check("release_instret", instret, 64'd10);

    // Stall and flush together
    step(mk(2'd0, 3'd0, 5'd9, 32'h99, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    step(bub, 1'b1, 1'b1);
    check("sf_validW", {63'd0, validW}, 64'd0);
    check("sf_instret", instret, 64'd10);

    // Mid-stream reset, then 17 retirements wrap the 4-bit counter
    reset_mid();
    for (int i = 0; i < 17; i++)
      step(mk(2'd0, 3'd0, 5'(i + 1), 32'(i), 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
    step(bub, 1'b0, 1'b0);
    check("wrap_instret4", {60'd0, instret4}, 64'd1);
    check("wrap_instret", instret, 64'd17);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      logic st, fl;
      m.valid = ($urandom_range(0, 9) != 0);
      m.rw    = ($urandom_range(0, 4) != 0);
      m.src   = 2'($urandom);
      m.lt    = 3'($urandom);
      m.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      m.alu   = $urandom;
      m.rdata = $urandom;
      m.pc4   = $urandom;
      m.imm   = $urandom;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(m, st, fl);
    end
    for (int i = 0; i < 3; i++) step(bub, 1'b0, 1'b0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
